sensor_responder: RTL

- Sensor-node end of the polled UART sensor link: the counterpart to the polling master that sends a select byte and expects a data byte followed by a CRC byte.
- Each node listens on rx for the one-byte select frame. When the frame addresses this node, it answers on tx with a two-byte frame: data, then CRC-8.
- A latched alarm turns the reply into an alarm frame. Reuses the codebase's existing uart module for byte framing.

---
 rtl/sensor_link_pkg.sv | 33 +++
 rtl/crc8_gen.sv | 30 +++
 rtl/uart.sv | 121 ++++++++++++
 rtl/sensor_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sensor_link_pkg.sv
// ============================================================================
// Module      : sensor_link_pkg
// Description : Shared definitions for the polled UART sensor link: responder
//               state encodings, CRC-8 polynomial, node addressing limits and
//               the default alarm data code. Used by both the sensor-node
//               responder and the polling master's CRC checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sensor_link_pkg;

  // Responder state encodings (3-bit)
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_TURNAROUND = 3'd2;
  localparam logic [2:0] ST_SEND_DATA  = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA  = 3'd4;
  localparam logic [2:0] ST_SEND_CRC   = 3'd5;
  localparam logic [2:0] ST_WAIT_CRC   = 3'd6;

  // CRC-8: x^8+x^2+x+1, init 0, MSB-first, no reflection, no final XOR
  localparam logic [7:0] CRC_POLY = 8'h07;

  // Addressing: id 0 is broadcast, nodes are 1..MAX_NODE_ID
  localparam logic [2:0] BROADCAST_ID = 3'd0;
  localparam logic [2:0] MAX_NODE_ID  = 3'd5;

  localparam logic [7:0] DEFAULT_ALARM_CODE = 8'hFE;

endpackage

`default_nettype wire

// File: rtl/crc8_gen.sv
// ============================================================================
// Module      : crc8_gen
// Description : Combinational CRC-8 over a single byte, 8-step unrolled shift.
// Ports       : data_i [7:0] - byte to protect
//               crc_o  [7:0] - CRC-8 of data_i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_gen
  import sensor_link_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc;

  // With init 0 the data byte simply seeds the register before shifting.
  always_comb begin
    crc = data_i;
    for (int i = 0; i < 8; i++) begin
      crc = crc[7] ? ({crc[6:0], 1'b0} ^ CRC_POLY) : {crc[6:0], 1'b0};
    end
    crc_o = crc;
  end

endmodule

`default_nettype wire

// File: rtl/uart.sv
// ============================================================================
// Module      : uart
// Description : 8N1 UART byte framer. Transmitter starts on wr_en when idle;
//               receiver holds the last byte in dout with rdy set until
//               rdy_clr (a new byte completing in the same cycle wins).
// Ports       : clock, resetn      - clock, async active-low reset
//               din, wr_en         - byte to send, one-cycle start strobe
//               tx, tx_busy        - serial out (idles high), frame in flight
//               rx                 - serial in
//               rdy, rdy_clr, dout - received byte valid, clear, byte
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

  // Transmitter: shift register holds {stop, data, start}, LSB on the line.
  logic [9:0]    tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic          tx_busy_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else if (!tx_busy_q) begin
      if (wr_en) begin
        tx_shift_q <= {1'b1, din, 1'b0};
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        tx_busy_q  <= 1'b1;
      end
    end else if (tx_cnt_q != BIT_LAST) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
      end else begin
        tx_bit_q   <= tx_bit_q + 4'd1;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      end
    end
  end

  assign tx      = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign tx_busy = tx_busy_q;

  // Receiver: bit 0 is the start bit sampled mid-bit; a high sample there is
  // treated as a glitch and the frame is dropped.
  logic          rx_meta_q, rx_sync_q, rx_act_q, rdy_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, dout_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      if (rdy_clr) rdy_q <= 1'b0;
      if (!rx_act_q) begin
        if (!rx_sync_q) begin
          rx_act_q <= 1'b1;
          rx_cnt_q <= BIT_HALF;
          rx_bit_q <= '0;
        end
      end else if (rx_cnt_q != BIT_LAST) begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end else begin
        rx_cnt_q <= '0;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_sync_q) rx_act_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_act_q <= 1'b0;
          if (rx_sync_q) begin
            dout_q <= rx_shift_q;
            rdy_q  <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  assign rdy  = rdy_q;
  assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/sensor_responder.sv
// ============================================================================
// Module      : sensor_responder
// Description : Sensor-node end of the polled UART link. Decodes a one-byte
//               select frame; when addressed, replies with {data, CRC-8}, or
//               {ALARM_CODE, ~CRC-8} when the alarm latch is set.
// Ports       : clock, resetn             - clock, async active-low reset
//               rx, tx                    - UART from / to the master
//               sensor_data, sensor_valid - sample and capture strobe
//               alarm_in                  - sets the alarm latch
//               busy, alarm_pending       - not IDLE, alarm latch value
//               poll_count, alarm_count   - completed / alarm frame counters
//                                           (only with SENSOR_RESPONDER_STATS_EN)
// Options     : `define SENSOR_RESPONDER_STATS_EN adds the frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_responder
  import sensor_link_pkg::*;
#(
  parameter logic [2:0]  NODE_ID      = 3'd1,
  parameter logic [7:0]  ALARM_CODE   = DEFAULT_ALARM_CODE,
  parameter int unsigned TURNAROUND   = 16,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        rx,
  output logic        tx,
  input  logic [7:0]  sensor_data,
  input  logic        sensor_valid,
  input  logic        alarm_in,
  output logic        busy,
  output logic        alarm_pending
`ifdef SENSOR_RESPONDER_STATS_EN
  ,
  output logic [15:0] poll_count,
  output logic [15:0] alarm_count
`endif
);

  // Counter reloads to TURNAROUND-1 and exits at zero: TURNAROUND cycles.
  localparam logic [15:0] TAT_LOAD = 16'(TURNAROUND - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  id_q;
  logic [7:0]  sample_q, data_q, crc_q;
  logic        alarm_q, alarm_frame_q, busy_seen_q;
  logic [15:0] tat_q;

  logic        uart_rdy, uart_rdy_clr, uart_wr_en, uart_tx_busy;
  logic [7:0]  uart_dout, uart_din;
  logic [7:0]  frame_data, frame_crc;
  logic        alarm_clr;
  logic        unused_sel_hi;

  uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock  (clock),
    .resetn (resetn),
    .din    (uart_din),
    .wr_en  (uart_wr_en),
    .tx     (tx),
    .tx_busy(uart_tx_busy),
    .rx     (rx),
    .rdy    (uart_rdy),
    .rdy_clr(uart_rdy_clr),
    .dout   (uart_dout)
  );

  // Upper select bits carry no meaning on this link.
  assign unused_sel_hi = ^uart_dout[7:3];

  assign frame_data = alarm_q ? ALARM_CODE : sample_q;

  crc8_gen u_crc (
    .data_i(frame_data),
    .crc_o (frame_crc)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. WAIT_* leave only after tx_busy has been seen high and
  // then low, so the uart's one-cycle start latency cannot cause a false exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (uart_rdy) state_d = ST_DECODE;
      ST_DECODE:     state_d = (id_q == NODE_ID) ? ST_TURNAROUND : ST_IDLE;
      ST_TURNAROUND: if (tat_q == 16'd0) state_d = ST_SEND_DATA;
      ST_SEND_DATA:  if (!uart_tx_busy) state_d = ST_WAIT_DATA;
      ST_WAIT_DATA:  if (busy_seen_q && !uart_tx_busy) state_d = ST_SEND_CRC;
      ST_SEND_CRC:   state_d = ST_WAIT_CRC;
      ST_WAIT_CRC:   if (busy_seen_q && !uart_tx_busy) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    uart_rdy_clr = (state_q == ST_IDLE) && uart_rdy;
    uart_wr_en   = ((state_q == ST_SEND_DATA) && !uart_tx_busy) ||
                   (state_q == ST_SEND_CRC);
    uart_din     = (state_q == ST_SEND_CRC) ? crc_q : data_q;
    busy         = (state_q != ST_IDLE);
    alarm_clr    = ((state_q == ST_SEND_CRC) && alarm_frame_q) ||
                   ((state_q == ST_DECODE) && (id_q == BROADCAST_ID));
  end

  // Datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      id_q          <= '0;
      sample_q      <= '0;
      data_q        <= '0;
      crc_q         <= '0;
      alarm_frame_q <= 1'b0;
      alarm_q       <= 1'b0;
      busy_seen_q   <= 1'b0;
      tat_q         <= '0;
    end else begin
      if (sensor_valid) sample_q <= sensor_data;
      // Set has priority over a coincident clear.
      alarm_q <= alarm_in | (alarm_q & ~alarm_clr);
      if (uart_rdy_clr) id_q <= uart_dout[2:0];
      if ((state_q == ST_DECODE) && (id_q == NODE_ID)) begin
        data_q        <= frame_data;
        crc_q         <= alarm_q ? ~frame_crc : frame_crc;
        alarm_frame_q <= alarm_q;
        tat_q         <= TAT_LOAD;
      end else if ((state_q == ST_TURNAROUND) && (tat_q != 16'd0)) begin
        tat_q <= tat_q - 16'd1;
      end
      if ((state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_CRC))
        busy_seen_q <= busy_seen_q | uart_tx_busy;
      else
        busy_seen_q <= 1'b0;
    end
  end

  assign alarm_pending = alarm_q;

`ifdef SENSOR_RESPONDER_STATS_EN
  logic [15:0] poll_count_q, alarm_count_q;
  logic        frame_done;

  assign frame_done = (state_q == ST_WAIT_CRC) && (state_d == ST_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      poll_count_q  <= '0;
      alarm_count_q <= '0;
    end else if (frame_done) begin
      poll_count_q <= poll_count_q + 16'd1;
      if (alarm_frame_q) alarm_count_q <= alarm_count_q + 16'd1;
    end
  end

  assign poll_count  = poll_count_q;
  assign alarm_count = alarm_count_q;
`endif

endmodule

`default_nettype wire
